// File: rtl/p_reg_pkg.sv
// Shared definitions for the processor status register: flag-operation codes,
// flag bit positions and the packed/unpacked views of P.
package p_reg_pkg;

  localparam logic [3:0] FLG_NONE = 4'd0;
  localparam logic [3:0] FLG_ALU  = 4'd1;
  localparam logic [3:0] FLG_BIT  = 4'd2;
  localparam logic [3:0] FLG_LOAD = 4'd3;
  localparam logic [3:0] FLG_CLC  = 4'd4;
  localparam logic [3:0] FLG_SEC  = 4'd5;
  localparam logic [3:0] FLG_CLI  = 4'd6;
  localparam logic [3:0] FLG_SEI  = 4'd7;
  localparam logic [3:0] FLG_CLV  = 4'd8;
  localparam logic [3:0] FLG_CLD  = 4'd9;
  localparam logic [3:0] FLG_SED  = 4'd10;
  localparam logic [3:0] FLG_INT  = 4'd11;

  localparam int unsigned FLAG_N = 7;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_U = 5;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 0;

  // Only six flags are real storage; U and B exist only on the bus.
  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } p_flags_t;

  function automatic logic [7:0] pack_p(input p_flags_t f, input logic b);
    logic [7:0] r;
    r         = 8'h00;
    r[FLAG_N] = f.n;
    r[FLAG_V] = f.v;
    r[FLAG_U] = 1'b1;
    r[FLAG_B] = b;
    r[FLAG_D] = f.d;
    r[FLAG_I] = f.i;
    r[FLAG_Z] = f.z;
    r[FLAG_C] = f.c;
    return r;
  endfunction

  function automatic p_flags_t unpack_p(input logic [7:0] v);
    p_flags_t f;
    f.n = v[FLAG_N];
    f.v = v[FLAG_V];
    f.d = v[FLAG_D];
    f.i = v[FLAG_I];
    f.z = v[FLAG_Z];
    f.c = v[FLAG_C];
    return f;
  endfunction

endpackage

// File: rtl/p_reg.sv
// 6502 processor status register stage downstream of the ALU, with an
// instruction-boundary-delayed copy of I for the interrupt logic.
module p_reg
  import p_reg_pkg::*;
#(
  parameter logic [7:0] RESET_P = 8'h34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sync,
  input  logic [3:0] flag_op,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic [7:0] db_in,
  input  logic       push_brk,
  output logic [7:0] p,
  output logic [7:0] p_push,
  output logic       c_out,
  output logic       d_out,
  output logic       irq_mask
);

  p_flags_t flags_q, flags_d;
  logic     irq_mask_q, irq_mask_d;
  logic     alu_zero;

  assign alu_zero = (alu_out == 8'h00);

  always_comb begin
    flags_d = flags_q;
    unique case (flag_op)
      FLG_ALU: begin
        if (upd_nz) begin
          flags_d.n = alu_out[7];
          flags_d.z = alu_zero;
        end
        if (upd_c) flags_d.c = alu_c;
        if (upd_v) flags_d.v = alu_v;
      end
      FLG_BIT: begin
        flags_d.n = db_in[7];
        flags_d.v = db_in[6];
        flags_d.z = alu_zero;
      end
      FLG_LOAD: flags_d = unpack_p(db_in);
      FLG_CLC:  flags_d.c = 1'b0;
      FLG_SEC:  flags_d.c = 1'b1;
      FLG_CLI:  flags_d.i = 1'b0;
      FLG_SEI:  flags_d.i = 1'b1;
      FLG_CLV:  flags_d.v = 1'b0;
      FLG_CLD:  flags_d.d = 1'b0;
      FLG_SED:  flags_d.d = 1'b1;
      // NMOS parts leave D alone on interrupt entry.
      FLG_INT:  flags_d.i = 1'b1;
      default:  flags_d = flags_q;
    endcase
  end

  // Sampling the stored I (not flags_d) at the fetch boundary delays a mask
  // change by one full instruction, as on the original part.
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (sync) irq_mask_d = flags_q.i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q    <= unpack_p(RESET_P);
      irq_mask_q <= RESET_P[FLAG_I];
    end else if (en) begin
      flags_q    <= flags_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  assign p        = pack_p(flags_q, 1'b1);
  assign p_push   = pack_p(flags_q, push_brk);
  assign c_out    = flags_q.c;
  assign d_out    = flags_q.d;
  assign irq_mask = irq_mask_q;

endmodule

// File: tb/tb_p_reg.sv
// Scoreboard bench for p_reg: a driver applies stimulus and pushes the
// expected outputs of a byte-level P model; a monitor pops and compares.
module tb_p_reg;

  localparam int W = 19;  // {p, p_push, irq_mask, c_out, d_out}

  logic       clk = 1'b0;
  logic       rst, en, sync;
  logic [3:0] flag_op;
  logic       upd_nz, upd_c, upd_v;
  logic [7:0] alu_out;
  logic       alu_c, alu_v;
  logic [7:0] db_in;
  logic       push_brk;
  logic [7:0] p, p_push;
  logic       c_out, d_out, irq_mask;

  always #5 clk = ~clk;

  p_reg #(.RESET_P(8'h34)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .flag_op(flag_op),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v),
    .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
    .db_in(db_in), .push_brk(push_brk),
    .p(p), .p_push(p_push), .c_out(c_out), .d_out(d_out), .irq_mask(irq_mask)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: P kept as a plain byte, bits 5 and 4 always set.
  logic [7:0] m_p;
  logic       m_irq;

  task automatic model_step();
    logic old_i;
    if (rst) begin
      m_p   = 8'h34;
      m_irq = 1'b1;
    end else if (en) begin
      old_i = m_p[2];
      case (flag_op)
        4'd1: begin
          if (upd_nz) begin
            m_p[7] = alu_out[7];
            m_p[1] = (alu_out == 8'h00);
          end
          if (upd_c) m_p[0] = alu_c;
          if (upd_v) m_p[6] = alu_v;
        end
        4'd2: begin
          m_p[7] = db_in[7];
          m_p[6] = db_in[6];
          m_p[1] = (alu_out == 8'h00);
        end
        4'd3:  m_p = db_in | 8'h30;
        4'd4:  m_p[0] = 1'b0;
        4'd5:  m_p[0] = 1'b1;
        4'd6:  m_p[2] = 1'b0;
        4'd7:  m_p[2] = 1'b1;
        4'd8:  m_p[6] = 1'b0;
        4'd9:  m_p[3] = 1'b0;
        4'd10: m_p[3] = 1'b1;
        4'd11: m_p[2] = 1'b1;
        default: ;
      endcase
      if (sync) m_irq = old_i;
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue the expectation
  // for the state visible after the next rising edge.
  task automatic drive(input logic r, input logic e, input logic s,
                       input logic [3:0] op, input logic [2:0] masks,
                       input logic [7:0] ao, input logic ac, input logic av,
                       input logic [7:0] db, input logic pb);
    logic [7:0] exp_push;
    @(negedge clk);
    rst = r; en = e; sync = s; flag_op = op;
    upd_nz = masks[2]; upd_c = masks[1]; upd_v = masks[0];
    alu_out = ao; alu_c = ac; alu_v = av; db_in = db; push_brk = pb;
    model_step();
    exp_push = (m_p & 8'hEF) | {3'b000, pb, 4'b0000};
    exp_q.push_back({m_p, exp_push, m_irq, m_p[0], m_p[3]});
  endtask

  task automatic simple(input logic [3:0] op, input logic s, input logic e, input logic pb);
    drive(1'b0, e, s, op, 3'b000, 8'h5A, 1'b0, 1'b0, 8'hA5, pb);
  endtask

  initial begin : monitor
    logic [W-1:0] exp, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {p, p_push, irq_mask, c_out, d_out};
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL out @%0t: got p=%h push=%h irq=%b c=%b d=%b, want p=%h push=%h irq=%b c=%b d=%b",
                   $time, got[18:11], got[10:3], got[2], got[1], got[0],
                   exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; en = 1'b0; sync = 1'b0; flag_op = 4'd0;
    upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0;
    alu_out = 8'h00; alu_c = 1'b0; alu_v = 1'b0; db_in = 8'h00; push_brk = 1'b0;
    m_p = 8'h00; m_irq = 1'b0;

    // Reset, then hold with en=0 while SEC is presented.
    drive(1'b1, 1'b1, 1'b0, 4'd0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'd5, 3'b111, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) simple(4'd5, i[0], 1'b0, 1'b0);

    // ALU with all masks, then N/Z only.
    drive(1'b0, 1'b1, 1'b0, 4'd1, 3'b111, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd1, 3'b100, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd1, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    // BIT and LOAD, then push encoding both ways.
    simple(4'd4, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd2, 3'b000, 8'h00, 1'b1, 1'b0, 8'hC0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 3'b111, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0);
    simple(4'd0, 1'b0, 1'b1, 1'b0);
    simple(4'd0, 1'b0, 1'b1, 1'b1);

    // Mask latency: SEI, boundary, CLI, then boundaries later.
    simple(4'd7, 1'b0, 1'b1, 1'b0);
    simple(4'd0, 1'b1, 1'b1, 1'b0);
    simple(4'd6, 1'b0, 1'b1, 1'b0);
    simple(4'd0, 1'b0, 1'b1, 1'b0);
    simple(4'd0, 1'b1, 1'b1, 1'b0);
    simple(4'd0, 1'b0, 1'b1, 1'b0);
    // Same with en=0 on the boundary cycle.
    simple(4'd7, 1'b0, 1'b1, 1'b0);
    simple(4'd0, 1'b1, 1'b1, 1'b0);
    simple(4'd0, 1'b0, 1'b1, 1'b0);
    simple(4'd6, 1'b0, 1'b1, 1'b0);
    simple(4'd0, 1'b1, 1'b0, 1'b0);
    simple(4'd0, 1'b0, 1'b1, 1'b0);
    // Every single-flag op, including INT, CLV, CLD and an unused code.
    for (int k = 4; k <= 15; k++) simple(k[3:0], k[0], 1'b1, k[1]);

    // Reset mid-sequence.
    simple(4'd10, 1'b0, 1'b1, 1'b0);
    simple(4'd6, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 4'd9, 3'b111, 8'h80, 1'b1, 1'b1, 8'hFF, 1'b1);
    simple(4'd0, 1'b0, 1'b1, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
            1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
